// File: rtl/weather_frame_transceiver.sv
// Hour-window-gated transceiver: buffers one multi-channel sensor sample and serialises it
// as a framed, checksummed, LSB-first bit stream (start, sync A5, data, checksum, stop).
module weather_frame_transceiver #(
  parameter int unsigned N_CH         = 3,
  parameter int unsigned DATA_W       = 6,
  parameter int unsigned WIN_START    = 8,
  parameter int unsigned WIN_END      = 20,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             current_hour,
  input  logic                   sample_valid,
  input  logic [N_CH*DATA_W-1:0] sample_data,
  output logic                   sample_ready,
  output logic                   enable_transceiver,
  output logic                   tx_serial,
  output logic                   tx_busy,
  output logic                   frame_done,
  output logic [7:0]             drop_count,
  output logic [2:0]             signal
);

  localparam int unsigned DW      = N_CH * DATA_W;
  localparam int unsigned FRAME_W = DW + 18;
  localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StSync  = 3'd2,
    StData  = 3'd3,
    StCsum  = 3'd4,
    StStop  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [7:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [DW-1:0]      buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               tx_q, tx_d;
  logic               en_q;
  logic [7:0]         drop_q, drop_d;
  logic [7:0]         csum;
  logic [7:0]         phase_len;
  logic               bit_end, phase_end, accept;

  function automatic logic in_window(input logic [4:0] h);
    logic [4:0] s, e;
    s = 5'(WIN_START);
    e = 5'(WIN_END);
    if (h > 5'd23) return 1'b0;
    if (s < e) return (h >= s) && (h < e);
    if (s > e) return (h >= s) || (h < e);
    return 1'b0;
  endfunction

  // Checksum of zero-extended channels, wrapping at 8 bits.
  always_comb begin
    csum = 8'd0;
    for (int i = 0; i < int'(N_CH); i++) begin
      csum = csum + 8'(buf_q[i*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    case (state_q)
      StSync:  phase_len = 8'd8;
      StData:  phase_len = 8'(DW);
      StCsum:  phase_len = 8'd8;
      default: phase_len = 8'd1;
    endcase
  end

  assign bit_end   = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign phase_end = bit_end && (bit_cnt_q == phase_len - 8'd1);
  assign sample_ready = !buf_full_q && !rst;
  assign accept    = sample_valid && sample_ready;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    drop_d     = drop_q;
    frame_done = 1'b0;

    if (accept) begin
      buf_d      = sample_data;
      buf_full_d = 1'b1;
    end

    if (state_q == StIdle) begin
      clk_cnt_d = '0;
      bit_cnt_d = 8'd0;
      if (buf_full_q) begin
        buf_full_d = 1'b0;
        if (en_q) begin
          frame_d = {1'b1, csum, buf_q, 8'hA5, 1'b0};
          state_d = StStart;
        end else if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
    end else begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
      if (bit_end) begin
        frame_d   = frame_q >> 1;
        bit_cnt_d = phase_end ? 8'd0 : bit_cnt_q + 8'd1;
      end
      if (phase_end) begin
        unique case (state_q)
          StStart: state_d = StSync;
          StSync:  state_d = StData;
          StData:  state_d = StCsum;
          StCsum:  state_d = StStop;
          StStop: begin
            state_d    = StIdle;
            frame_done = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    // Line register follows the next bit so the START bit appears the edge after loading.
    tx_d = (state_d == StIdle) ? 1'b1 : frame_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= 8'd0;
      frame_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
      en_q       <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_q       <= tx_d;
      en_q       <= in_window(current_hour);
      drop_q     <= drop_d;
    end
  end

  assign enable_transceiver = en_q;
  assign tx_serial          = tx_q;
  assign tx_busy            = (state_q != StIdle);
  assign drop_count         = drop_q;
  assign signal             = state_q;

endmodule

// File: tb/tb_weather_frame_transceiver.sv
// Directed bench: hour-window vector table plus hand-written frame, back-to-back, drop and
// mid-frame reset sequences.
module tb_weather_frame_transceiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  current_hour;
  logic        sample_valid;
  logic [17:0] sample_data;
  logic        sample_ready, enable_transceiver, tx_serial, tx_busy, frame_done;
  logic [7:0]  drop_count;
  logic [2:0]  signal;

  logic        w_ready, w_en, w_tx, w_busy, w_done;
  logic [7:0]  w_drop;
  logic [2:0]  w_signal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weather_frame_transceiver u_dut (
    .clk                (clk),
    .rst                (rst),
    .current_hour       (current_hour),
    .sample_valid       (sample_valid),
    .sample_data        (sample_data),
    .sample_ready       (sample_ready),
    .enable_transceiver (enable_transceiver),
    .tx_serial          (tx_serial),
    .tx_busy            (tx_busy),
    .frame_done         (frame_done),
    .drop_count         (drop_count),
    .signal             (signal)
  );

  weather_frame_transceiver #(.WIN_START(22), .WIN_END(6)) u_wrap (
    .clk                (clk),
    .rst                (rst),
    .current_hour       (current_hour),
    .sample_valid       (1'b0),
    .sample_data        (18'd0),
    .sample_ready       (w_ready),
    .enable_transceiver (w_en),
    .tx_serial          (w_tx),
    .tx_busy            (w_busy),
    .frame_done         (w_done),
    .drop_count         (w_drop),
    .signal             (w_signal)
  );

  typedef struct {
    logic [4:0] hour;
    logic       en_def;
    logic       en_wrap;
  } win_vec_t;

  win_vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] state_of(input int b);
    if (b == 0) return 3'd1;
    if (b <= 8) return 3'd2;
    if (b <= 26) return 3'd3;
    if (b <= 34) return 3'd4;
    return 3'd5;
  endfunction

  task automatic send(input logic [17:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Waits for a frame, then checks all 144 cycles of line, state, busy and frame_done.
  task automatic check_frame(input logic [17:0] d, input logic [7:0] cs, input string name,
                             output int waited);
    logic [35:0] exp;
    int line_err, st_err, done_err, idle_err;
    exp = {1'b1, cs, d, 8'hA5, 1'b0};
    line_err = 0; st_err = 0; done_err = 0; idle_err = 0;
    waited = 0;
    @(negedge clk);
    while (!tx_busy && waited < 40) begin
      if (tx_serial !== 1'b1) idle_err++;
      waited++;
      @(negedge clk);
    end
    check({name, " started"}, 32'(tx_busy), 32'd1);
    for (int c = 0; c < 144; c++) begin
      if (tx_serial !== exp[c/4]) begin
        if (line_err == 0)
          $display("FAIL %s line cycle %0d: got %0b expected %0b", name, c, tx_serial, exp[c/4]);
        line_err++;
      end
      if (signal !== state_of(c/4) || tx_busy !== 1'b1) st_err++;
      if (frame_done !== (c == 143)) done_err++;
      if (c < 143) @(negedge clk);
    end
    check({name, " line errs"}, 32'(line_err), 32'd0);
    check({name, " state errs"}, 32'(st_err), 32'd0);
    check({name, " frame_done errs"}, 32'(done_err), 32'd0);
    check({name, " idle line errs"}, 32'(idle_err), 32'd0);
  endtask

  initial begin
    int waited_a, waited_b, waited_c, err_cnt;

    vecs[0]  = '{5'd10, 1'b1, 1'b0};
    vecs[1]  = '{5'd3,  1'b0, 1'b1};
    vecs[2]  = '{5'd27, 1'b0, 1'b0};
    vecs[3]  = '{5'd23, 1'b0, 1'b1};
    vecs[4]  = '{5'd5,  1'b0, 1'b1};
    vecs[5]  = '{5'd6,  1'b0, 1'b0};
    vecs[6]  = '{5'd12, 1'b1, 1'b0};
    vecs[7]  = '{5'd8,  1'b1, 1'b0};
    vecs[8]  = '{5'd20, 1'b0, 1'b0};
    vecs[9]  = '{5'd22, 1'b0, 1'b1};
    vecs[10] = '{5'd19, 1'b1, 1'b0};
    vecs[11] = '{5'd0,  1'b0, 1'b1};

    rst = 1'b1; current_hour = 5'd12; sample_valid = 1'b0; sample_data = '0;
    repeat (3) @(negedge clk);
    check("reset tx_serial", 32'(tx_serial), 32'd1);
    check("reset tx_busy", 32'(tx_busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset drop_count", 32'(drop_count), 32'd0);
    check("reset signal", 32'(signal), 32'd0);
    check("reset enable", 32'(enable_transceiver), 32'd0);
    check("reset ready low", 32'(sample_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", 32'(sample_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      current_hour = vecs[i].hour;
      @(negedge clk);
      check($sformatf("window default hour %0d", vecs[i].hour),
            32'(enable_transceiver), 32'(vecs[i].en_def));
      check($sformatf("window wrap hour %0d", vecs[i].hour), 32'(w_en), 32'(vecs[i].en_wrap));
    end

    // Single frame.
    current_hour = 5'd12;
    repeat (2) @(negedge clk);
    send({6'h1F, 6'h2A, 6'h15});
    check_frame({6'h1F, 6'h2A, 6'h15}, 8'h5E, "frame1", waited_a);
    @(negedge clk);
    check("frame1 idle after", 32'({tx_busy, tx_serial, signal}), 32'({1'b0, 1'b1, 3'd0}));
    check("frame1 no drops", 32'(drop_count), 32'd0);

    // Back-to-back: B accepted mid-frame, C refused.
    fork
      begin
        check_frame({6'h03, 6'h02, 6'h01}, 8'h06, "frameA", waited_a);
        check_frame({6'h3F, 6'h3F, 6'h3F}, 8'hBD, "frameB", waited_b);
        check("one idle cycle between frames", 32'(waited_b), 32'd1);
      end
      begin
        send({6'h03, 6'h02, 6'h01});
        repeat (12) @(negedge clk);
        check("ready mid-frame", 32'(sample_ready), 32'd1);
        sample_data = {6'h3F, 6'h3F, 6'h3F};
        sample_valid = 1'b1;
        @(negedge clk);
        check("ready blocked", 32'(sample_ready), 32'd0);
        sample_data = {6'h11, 6'h22, 6'h33};
        @(negedge clk);
        sample_valid = 1'b0;
      end
    join
    err_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx_serial !== 1'b1) err_cnt++;
    end
    check("refused sample not sent", 32'(err_cnt), 32'd0);
    check("refused sample not dropped", 32'(drop_count), 32'd0);

    // Out-of-window drops with saturation.
    current_hour = 5'd3;
    repeat (2) @(negedge clk);
    err_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      sample_data = 18'(i);
      sample_valid = 1'b1;
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) err_cnt++;
      sample_valid = 1'b0;
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) err_cnt++;
      if (i == 9) check("drop_count after 10", 32'(drop_count), 32'd10);
    end
    repeat (2) @(negedge clk);
    check("disabled line idle", 32'(err_cnt), 32'd0);
    check("drop_count saturated", 32'(drop_count), 32'd255);

    // Reset during DATA.
    current_hour = 5'd12;
    repeat (2) @(negedge clk);
    send({6'h07, 6'h07, 6'h07});
    waited_c = 0;
    while (signal !== 3'd3 && waited_c < 80) begin
      waited_c++;
      @(negedge clk);
    end
    check("reached DATA", 32'(signal), 32'd3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort tx_serial", 32'(tx_serial), 32'd1);
    check("abort tx_busy", 32'(tx_busy), 32'd0);
    check("abort signal", 32'(signal), 32'd0);
    check("abort drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort buffer empty", 32'(sample_ready), 32'd1);
    check("abort stays idle", 32'(tx_busy), 32'd0);
    send({6'h00, 6'h15, 6'h2A});
    check_frame({6'h00, 6'h15, 6'h2A}, 8'h3F, "frame after reset", waited_c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
